// File: rtl/shop_pkg.sv
// Shared types and constants for the shop queue scheduler and its service counters.
package shop_pkg;

  localparam int NUM_W_DEF    = 4;
  localparam int TIME_W_DEF   = 4;
  localparam int TICKET_FIRST = 1;

  // One waiting customer as stored in the queue at default widths.
  typedef struct packed {
    logic [NUM_W_DEF-1:0]  num;
    logic [TIME_W_DEF-1:0] svcTime;
  } cust_t;

endpackage

// File: rtl/ticket_fifo.sv
// Synchronous FIFO holding waiting customers; count/full/empty come from registered state only.
module ticket_fifo
  import shop_pkg::*;
#(
  parameter int WIDTH  = $bits(cust_t),
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              doPush, doPop;

  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign doPush = push_i & ~full_o;
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/queue_dispatcher.sv
// Issues tickets to arriving customers, queues them, and hands the queue head to the
// next free service counter in round-robin order via a registered one-hot load pulse.
module queue_dispatcher
  import shop_pkg::*;
#(
  parameter int NUM_W  = NUM_W_DEF,
  parameter int TIME_W = TIME_W_DEF,
  parameter int N_CTR  = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              open,
  input  logic              arr_valid,
  input  logic [TIME_W-1:0] arr_time,
  output logic              arr_ready,
  output logic [NUM_W-1:0]  issued_num,
  input  logic [N_CTR-1:0]  ctr_busy,
  output logic [N_CTR-1:0]  ctr_ld,
  output logic [NUM_W-1:0]  ctr_num,
  output logic [TIME_W-1:0] ctr_time,
  output logic [ADDR_W:0]   wait_cnt,
  output logic              empty
);

  localparam int PTR_W = (N_CTR > 1) ? $clog2(N_CTR) : 1;

  typedef struct packed {
    logic [NUM_W-1:0]  num;
    logic [TIME_W-1:0] svcTime;
  } entry_t;

  logic [NUM_W-1:0]  ticket_q, ticket_d;
  logic [NUM_W-1:0]  issued_q, issued_d;
  logic [N_CTR-1:0]  ld_q, ld_d;
  logic [NUM_W-1:0]  num_q, num_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [N_CTR-1:0]  reserved_q, reserved_d;
  logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;

  entry_t            pushEntry, headEntry;
  logic              fifoFull, fifoEmpty;
  logic              accept, dispatch;
  logic [N_CTR-1:0]  free, grantOneHot;
  logic              grantValid;
  logic [PTR_W-1:0]  grantIdx, scanIdx;
  int                scanInt;

  assign arr_ready = ~fifoFull;
  assign accept    = arr_valid & ~fifoFull;
  assign pushEntry = '{num: ticket_q, svcTime: arr_time};

  ticket_fifo #(
    .WIDTH  ($bits(entry_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i (pushEntry),
    .pop_i   (dispatch),
    .rdata_o (headEntry),
    .count_o (wait_cnt),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign empty = fifoEmpty;

  // A counter just granted stays reserved until its busy flag is seen, bridging the load latency.
  assign free = ~ctr_busy & ~reserved_q;

  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    scanInt    = 0;
    scanIdx    = '0;
    for (int k = 0; k < N_CTR; k++) begin
      scanInt = (int'(rrPtr_q) + k) % N_CTR;
      scanIdx = PTR_W'(scanInt);
      if (!grantValid && free[scanIdx]) begin
        grantValid = 1'b1;
        grantIdx   = scanIdx;
      end
    end
  end

  assign dispatch    = open & ~fifoEmpty & grantValid;
  assign grantOneHot = N_CTR'(1) << grantIdx;

  always_comb begin
    ticket_d   = ticket_q;
    issued_d   = issued_q;
    ld_d       = '0;
    num_d      = num_q;
    time_d     = time_q;
    rrPtr_d    = rrPtr_q;
    reserved_d = reserved_q & ~ctr_busy;
    // Ticket 0 means idle on the counter side, so the generator skips it on wrap.
    if (accept) begin
      issued_d = ticket_q;
      ticket_d = (ticket_q == {NUM_W{1'b1}}) ? NUM_W'(TICKET_FIRST) : ticket_q + 1'b1;
    end
    if (dispatch) begin
      ld_d       = grantOneHot;
      num_d      = headEntry.num;
      time_d     = headEntry.svcTime;
      reserved_d = reserved_d | grantOneHot;
      rrPtr_d    = (grantIdx == PTR_W'(N_CTR-1)) ? '0 : grantIdx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ticket_q   <= NUM_W'(TICKET_FIRST);
      issued_q   <= '0;
      ld_q       <= '0;
      num_q      <= '0;
      time_q     <= '0;
      reserved_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      ticket_q   <= ticket_d;
      issued_q   <= issued_d;
      ld_q       <= ld_d;
      num_q      <= num_d;
      time_q     <= time_d;
      reserved_q <= reserved_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign issued_num = issued_q;
  assign ctr_ld     = ld_q;
  assign ctr_num    = num_q;
  assign ctr_time   = time_q;

endmodule

// File: tb/tb_queue_dispatcher.sv
// Randomized bench for queue_dispatcher against a queue-based reference model with
// behavioural service counters; 2-bit tickets exercise the 1,2,3,1 wrap.
module tb_queue_dispatcher;

  localparam int NUM_W  = 2;
  localparam int TIME_W = 4;
  localparam int N_CTR  = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk;
  logic              rst_n;
  logic              open;
  logic              arr_valid;
  logic [TIME_W-1:0] arr_time;
  logic              arr_ready;
  logic [NUM_W-1:0]  issued_num;
  logic [N_CTR-1:0]  ctr_busy;
  logic [N_CTR-1:0]  ctr_ld;
  logic [NUM_W-1:0]  ctr_num;
  logic [TIME_W-1:0] ctr_time;
  logic [ADDR_W:0]   wait_cnt;
  logic              empty;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int num;
    int tm;
  } cust_s;

  cust_s modelQ[$];
  int    nextTicket;
  int    expIssued;
  int    rr;
  int    expLd;
  int    expNum;
  int    expTime;
  bit    resv[N_CTR];
  int    rem[N_CTR];

  queue_dispatcher #(
    .NUM_W  (NUM_W),
    .TIME_W (TIME_W),
    .N_CTR  (N_CTR),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .open       (open),
    .arr_valid  (arr_valid),
    .arr_time   (arr_time),
    .arr_ready  (arr_ready),
    .issued_num (issued_num),
    .ctr_busy   (ctr_busy),
    .ctr_ld     (ctr_ld),
    .ctr_num    (ctr_num),
    .ctr_time   (ctr_time),
    .wait_cnt   (wait_cnt),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    nextTicket = 1;
    expIssued  = 0;
    rr         = 0;
    expLd      = 0;
    expNum     = 0;
    expTime    = 0;
    for (int i = 0; i < N_CTR; i++) begin
      resv[i] = 1'b0;
      rem[i]  = 0;
    end
  endtask

  task automatic checkAll();
    checkOutput("ctr_ld", 32'(ctr_ld), 32'(expLd));
    checkOutput("ctr_num", 32'(ctr_num), 32'(expNum));
    checkOutput("ctr_time", 32'(ctr_time), 32'(expTime));
    checkOutput("issued_num", 32'(issued_num), 32'(expIssued));
    checkOutput("wait_cnt", 32'(wait_cnt), 32'(modelQ.size()));
    checkOutput("empty", 32'(empty), 32'(modelQ.size() == 0));
    checkOutput("arr_ready", 32'(arr_ready), 32'(modelQ.size() < DEPTH));
    checkOutput("ldAtMostOneHot", 32'($countones(ctr_ld) <= 1), 32'd1);
    if (ctr_ld != '0) checkOutput("ldTicketNonZero", 32'(ctr_num != '0), 32'd1);
    for (int i = 0; i < N_CTR; i++)
      if (ctr_ld[i]) checkOutput("ldToIdleCounter", 32'(rem[i]), 32'd0);
  endtask

  // Advances the model across the coming rising edge using the inputs now applied.
  task automatic modelStep(input bit v, input int t, input bit o);
    int  size;
    bit  accept;
    int  g;
    int  idx;
    size   = modelQ.size();
    accept = v && (size < DEPTH);
    g      = -1;
    if (o && size > 0) begin
      for (int k = 0; k < N_CTR; k++) begin
        idx = (rr + k) % N_CTR;
        if (g < 0 && !ctr_busy[idx] && !resv[idx]) g = idx;
      end
    end
    for (int i = 0; i < N_CTR; i++) begin
      if (ctr_busy[i]) resv[i] = 1'b0;
      if (ctr_ld[i]) rem[i] = (ctr_time == '0) ? 1 : int'(ctr_time);
      else if (rem[i] > 0) rem[i] = rem[i] - 1;
    end
    if (g >= 0) begin
      expLd   = 1 << g;
      expNum  = modelQ[0].num;
      expTime = modelQ[0].tm;
      resv[g] = 1'b1;
      rr      = (g + 1) % N_CTR;
      void'(modelQ.pop_front());
    end else begin
      expLd = 0;
    end
    if (accept) begin
      modelQ.push_back('{num: nextTicket, tm: t});
      expIssued  = nextTicket;
      nextTicket = (nextTicket == (1 << NUM_W) - 1) ? 1 : nextTicket + 1;
    end
  endtask

  // Called at a falling edge: check, drive busy and inputs, step model, move to next falling edge.
  task automatic applyStimulus(input bit v, input int t, input bit o);
    checkAll();
    for (int i = 0; i < N_CTR; i++) ctr_busy[i] = (rem[i] != 0);
    arr_valid = v;
    arr_time  = TIME_W'(t);
    open      = o;
    modelStep(v, t, o);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit resetDone;
    rst_n     = 1'b0;
    open      = 1'b0;
    arr_valid = 1'b0;
    arr_time  = '0;
    ctr_busy  = '0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 0, 1'b1);

    applyStimulus(1'b1, 3, 1'b1);
    applyStimulus(1'b1, 5, 1'b1);
    for (int c = 0; c < 14; c++) applyStimulus(1'b0, 0, 1'b1);

    for (int c = 0; c < 5; c++) applyStimulus(1'b1, c + 1, 1'b0);
    for (int c = 0; c < 2; c++) applyStimulus(1'b1, 5, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 5, 1'b1);
    for (int c = 0; c < 40; c++) applyStimulus(1'b0, 0, 1'b1);

    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 99) < 45, int'($urandom_range(0, 6)), $urandom_range(0, 9) != 0);

    resetDone = 1'b0;
    for (int c = 0; c < 60 && !resetDone; c++) begin
      applyStimulus(1'b1, 2, 1'b1);
      if (expLd != 0) begin
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetLd", 32'(ctr_ld), 32'd0);
        checkOutput("asyncResetWaitCnt", 32'(wait_cnt), 32'd0);
        checkOutput("asyncResetIssued", 32'(issued_num), 32'd0);
        modelReset();
        arr_valid = 1'b0;
        ctr_busy  = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        resetDone = 1'b1;
      end
    end
    if (!resetDone) checkOutput("resetWaitTimeout", 32'd0, 32'd1);

    applyStimulus(1'b1, 4, 1'b1);
    checkOutput("ticketAfterReset", 32'(issued_num), 32'd1);
    for (int c = 0; c < 20; c++) applyStimulus(1'b0, 0, 1'b1);
    checkAll();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
